// File: rtl/modn_ctrl_pkg.sv
// ==========================================================================
// modn_ctrl_pkg : shared state encoding and constants for the mod-N sequencer
// Revision 1.0
// ==========================================================================
`default_nettype none

package modn_ctrl_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_HOLD = 2'd2;

   localparam int   MIN_MOD = 2;
   localparam logic DIR_UP  = 1'b1;
   localparam logic DIR_DN  = 1'b0;

endpackage

`default_nettype wire

// File: rtl/modn_updown_core.sv
// ==========================================================================
// modn_updown_core : mod-N up/down counter datapath; reverses at the ends
// instead of wrapping when MODN_PINGPONG_EN is defined and pingpong is set.
// Revision 1.0
// ==========================================================================
`default_nettype none

module modn_updown_core
   import modn_ctrl_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             dir,
   input  logic [WIDTH:0]   mod_n_eff,
`ifdef MODN_PINGPONG_EN
   input  logic             pingpong,
`endif
   output logic [WIDTH-1:0] count,
   output logic             term
);

   localparam logic [WIDTH-1:0] c_one   = WIDTH'(1);
   localparam logic [WIDTH:0]   c_one_x = (WIDTH+1)'(1);

   logic [WIDTH-1:0] count_q, count_d;
   logic             dir_q, dir_d;
   logic [WIDTH:0]   w_top;
   logic             w_at_top, w_at_bot;

   assign w_top    = mod_n_eff - c_one_x;
   assign w_at_top = ({1'b0, count_q} == w_top);
   assign w_at_bot = (count_q == '0);
   // term flags that the next step in the current direction is a wrap event
   assign term     = (dir_q == DIR_UP) ? w_at_top : w_at_bot;
   assign count    = count_q;

   always_comb begin
      count_d = count_q;
      dir_d   = dir_q;
      if (load) begin
         count_d = load_val;
         dir_d   = dir;
      end else if (en) begin
         if (dir_q == DIR_UP) begin
            if (w_at_top) begin
`ifdef MODN_PINGPONG_EN
               if (pingpong) begin
                  count_d = count_q - c_one;
                  dir_d   = DIR_DN;
               end else begin
                  count_d = '0;
               end
`else
               count_d = '0;
`endif
            end else begin
               count_d = count_q + c_one;
            end
         end else begin
            if (w_at_bot) begin
`ifdef MODN_PINGPONG_EN
               if (pingpong) begin
                  count_d = c_one;
                  dir_d   = DIR_UP;
               end else begin
                  count_d = w_top[WIDTH-1:0];
               end
`else
               count_d = w_top[WIDTH-1:0];
`endif
            end else begin
               count_d = count_q - c_one;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
         dir_q   <= DIR_UP;
      end else begin
         count_q <= count_d;
         dir_q   <= dir_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/modn_seq_ctrl.sv
// ==========================================================================
// modn_seq_ctrl : run/hold/abort sequencer around modn_updown_core with wrap
// budget and wrap/done pulses. Optional macro: MODN_PINGPONG_EN.
// Revision 1.0
// ==========================================================================
`default_nettype none

module modn_seq_ctrl
   import modn_ctrl_pkg::*;
#(
   parameter int WIDTH  = 4,
   parameter int WRAP_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              dir,
   input  logic [WIDTH:0]    mod_n,
   input  logic [WRAP_W-1:0] num_wraps,
   input  logic              hold,
   input  logic              abort,
`ifdef MODN_PINGPONG_EN
   input  logic              pingpong,
`endif
   output logic [WIDTH-1:0]  count,
   output logic              busy,
   output logic              wrap,
   output logic              done
);

   localparam logic [WIDTH:0]   c_min = (WIDTH+1)'(MIN_MOD);
   localparam logic [WIDTH:0]   c_max = {1'b1, {WIDTH{1'b0}}};
   localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

   state_t              state_q, state_d;
   logic [WIDTH:0]      mod_q;
   logic [WRAP_W-1:0]   nw_q;
   logic [WRAP_W-1:0]   wrap_cnt_q, wrap_cnt_d;
   logic                wrap_q, wrap_d;
   logic                done_q, done_d;

   logic [WIDTH:0]      w_mod_eff;
   logic [WIDTH-1:0]    w_load_val;
   logic [WRAP_W:0]     w_cnt_inc;
   logic                w_load, w_step, w_term, w_evt, w_final;

   always_comb begin
      if (mod_n < c_min)      w_mod_eff = c_min;
      else if (mod_n > c_max) w_mod_eff = c_max;
      else                    w_mod_eff = mod_n;
   end

   // Low WIDTH bits minus one also give 2**WIDTH-1 for the full-range modulus
   assign w_load_val = (dir == DIR_UP) ? '0 : (w_mod_eff[WIDTH-1:0] - c_one);
   assign w_cnt_inc  = {1'b0, wrap_cnt_q} + (WRAP_W+1)'(1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_RUN;
         ST_RUN: begin
            if (abort)        state_d = ST_IDLE;
            else if (hold)    state_d = ST_HOLD;
            else if (w_final) state_d = ST_IDLE;
         end
         ST_HOLD: begin
            if (abort)        state_d = ST_IDLE;
            else if (!hold)   state_d = ST_RUN;
         end
         default:             state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy       = (state_q != ST_IDLE);
      w_load     = (state_q == ST_IDLE) && start;
      w_step     = (state_q == ST_RUN) && !abort && !hold;
      w_evt      = w_step && w_term;
      w_final    = w_evt && (nw_q != '0) && (w_cnt_inc == {1'b0, nw_q});
      wrap_d     = w_evt;
      done_d     = w_final;
      wrap_cnt_d = wrap_cnt_q;
      if (w_load)
         wrap_cnt_d = '0;
      else if (w_evt && !w_cnt_inc[WRAP_W])
         wrap_cnt_d = w_cnt_inc[WRAP_W-1:0];
   end

`ifdef MODN_PINGPONG_EN
   logic pp_q;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mod_q      <= c_min;
         nw_q       <= '0;
         wrap_cnt_q <= '0;
         wrap_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef MODN_PINGPONG_EN
         pp_q       <= 1'b0;
`endif
      end else begin
         if (w_load) begin
            mod_q <= w_mod_eff;
            nw_q  <= num_wraps;
`ifdef MODN_PINGPONG_EN
            pp_q  <= pingpong;
`endif
         end
         wrap_cnt_q <= wrap_cnt_d;
         wrap_q     <= wrap_d;
         done_q     <= done_d;
      end
   end

   assign wrap = wrap_q;
   assign done = done_q;

   modn_updown_core #(
      .WIDTH     (WIDTH)
   ) u_core (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (w_load),
      .load_val  (w_load_val),
      .en        (w_step),
      .dir       (dir),
      .mod_n_eff (mod_q),
`ifdef MODN_PINGPONG_EN
      .pingpong  (pp_q),
`endif
      .count     (count),
      .term      (w_term)
   );

endmodule

`default_nettype wire

// File: tb/tb_modn_seq_ctrl.sv
// ==========================================================================
// tb_modn_seq_ctrl : scoreboard bench for modn_seq_ctrl with a behavioural model
// Revision 1.0
// ==========================================================================
`default_nettype none

module tb_modn_seq_ctrl;

   logic       clk = 1'b0;
   logic       reset_n, start, dir, hold, abort;
   logic [4:0] mod_n;
   logic [7:0] num_wraps;
   logic [3:0] count;
   logic       busy, wrap, done;
`ifdef MODN_PINGPONG_EN
   logic       pingpong;
`endif

   always #5 clk = ~clk;

   modn_seq_ctrl #(.WIDTH(4), .WRAP_W(8)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .dir       (dir),
      .mod_n     (mod_n),
      .num_wraps (num_wraps),
      .hold      (hold),
      .abort     (abort),
`ifdef MODN_PINGPONG_EN
      .pingpong  (pingpong),
`endif
      .count     (count),
      .busy      (busy),
      .wrap      (wrap),
      .done      (done)
   );

   typedef struct {
      int count;
      bit busy;
      bit wrap;
      bit done;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;

   // Behavioural model state
   bit m_run, m_holding, m_up, m_pp, m_wrap, m_done;
   int m_cnt, m_n, m_budget, m_wraps;

   task automatic model_reset();
      m_run = 0; m_holding = 0; m_up = 1; m_pp = 0;
      m_wrap = 0; m_done = 0;
      m_cnt = 0; m_n = 2; m_budget = 0; m_wraps = 0;
   endtask

   task automatic model_edge(input bit st, input bit d, input int mn, input int nw,
                             input bit h, input bit ab, input bit pp);
      bit wrapped;
      int nxt;
      m_wrap = 0;
      m_done = 0;
      if (!m_run) begin
         if (st) begin
            m_run = 1; m_holding = 0; m_up = d; m_pp = pp;
            m_n = (mn < 2) ? 2 : ((mn > 16) ? 16 : mn);
            m_cnt = d ? 0 : m_n - 1;
            m_budget = nw; m_wraps = 0;
         end
      end else if (ab) begin
         m_run = 0;
      end else if (m_holding) begin
         if (!h) m_holding = 0;
      end else if (h) begin
         m_holding = 1;
      end else begin
         wrapped = 0;
         if (m_pp && m_up && m_cnt == m_n - 1) begin
            nxt = m_n - 2; m_up = 0; wrapped = 1;
         end else if (m_pp && !m_up && m_cnt == 0) begin
            nxt = 1; m_up = 1; wrapped = 1;
         end else if (m_up) begin
            nxt = (m_cnt + 1) % m_n; wrapped = (nxt == 0);
         end else begin
            nxt = (m_cnt + m_n - 1) % m_n; wrapped = (nxt == m_n - 1);
         end
         m_cnt = nxt;
         if (wrapped) begin
            m_wrap = 1;
            if (m_wraps < 255) m_wraps++;
            if (m_budget != 0 && m_wraps == m_budget) begin
               m_run = 0;
               m_done = 1;
            end
         end
      end
   endtask

   // One clock of stimulus; the expected post-edge outputs go to the scoreboard
   task automatic drive(input bit st, input bit d, input int mn, input int nw,
                        input bit h, input bit ab, input bit pp, input bit rn);
      exp_t e;
      @(negedge clk);
      #1;
      reset_n = rn; start = st; dir = d; mod_n = 5'(mn); num_wraps = 8'(nw);
      hold = h; abort = ab;
`ifdef MODN_PINGPONG_EN
      pingpong = pp;
`endif
      if (!rn) begin
         model_reset();
      end else begin
`ifdef MODN_PINGPONG_EN
         model_edge(st, d, mn, nw, h, ab, pp);
`else
         model_edge(st, d, mn, nw, h, ab, 1'b0);
`endif
      end
      e.count = m_cnt; e.busy = m_run; e.wrap = m_wrap; e.done = m_done;
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (count === 4'(e.count) && busy === e.busy && wrap === e.wrap && done === e.done)
               n_pass++;
            else
               $display("FAIL outputs@cyc%0d: got count=%0d busy=%0b wrap=%0b done=%0b, expected count=%0d busy=%0b wrap=%0b done=%0b",
                        cyc, count, busy, wrap, done, e.count, e.busy, e.wrap, e.done);
         end
      end
   end

   initial begin : stim
      bit r_st, r_d, r_h, r_ab, r_pp;
      reset_n = 0; start = 0; dir = 0; mod_n = 0; num_wraps = 0; hold = 0; abort = 0;
`ifdef MODN_PINGPONG_EN
      pingpong = 0;
`endif
      model_reset();
      repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0);
      idle(2);

      // up mod 5, two wraps
      drive(1, 1, 5, 2, 0, 0, 0, 1);
      idle(13);
      // down mod 3, one wrap
      drive(1, 0, 3, 1, 0, 0, 0, 1);
      idle(6);
      // up mod 6 unlimited: hold at 3, release, ignored start, abort at 5
      drive(1, 1, 6, 0, 0, 0, 0, 1);
      idle(3);
      repeat (4) drive(0, 1, 6, 0, 1, 0, 0, 1);
      drive(0, 1, 6, 0, 0, 0, 0, 1);
      drive(1, 0, 3, 1, 0, 0, 0, 1);
      for (int k = 0; k < 40 && m_cnt != 5; k++) idle(1);
      drive(0, 0, 0, 0, 0, 1, 0, 1);
      idle(3);
      // modulus clamping
      drive(1, 1, 1, 3, 0, 0, 0, 1);
      idle(8);
      drive(1, 0, 0, 2, 0, 0, 0, 1);
      idle(6);
      drive(1, 1, 17, 1, 0, 0, 0, 1);
      idle(19);
      drive(1, 0, 31, 1, 0, 0, 0, 1);
      idle(19);
      // asynchronous reset mid-run
      drive(1, 1, 8, 0, 0, 0, 0, 1);
      idle(3);
      @(negedge clk);
      #3;
      reset_n = 0;
      #1;
      n_checks++;
      if (count === 4'd0 && busy === 1'b0) n_pass++;
      else $display("FAIL async_reset: got count=%0d busy=%0b, expected count=0 busy=0", count, busy);
      model_reset();
      repeat (2) drive(0, 0, 0, 0, 0, 0, 0, 0);
      idle(1);
      drive(1, 1, 4, 1, 0, 0, 0, 1);
      idle(7);
`ifdef MODN_PINGPONG_EN
      drive(1, 1, 4, 2, 0, 0, 1, 1);
      idle(10);
      drive(1, 0, 2, 3, 0, 0, 1, 1);
      idle(8);
`endif
      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         r_st = ($urandom_range(0, 7) == 0);
         r_d  = 1'($urandom_range(0, 1));
         r_h  = ($urandom_range(0, 5) == 0);
         r_ab = ($urandom_range(0, 29) == 0);
         r_pp = 1'($urandom_range(0, 1));
         drive(r_st, r_d, int'($urandom_range(0, 31)), int'($urandom_range(0, 4)),
               r_h, r_ab, r_pp, 1'b1);
      end
      idle(2);
      @(negedge clk);
      #2;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
